booking_req_sequencer: RTL and testbench

Host-side initiator for the multi-train reservation engine. It queues booking requests from a host, pre-validates each route and ticket count, and issues each valid request to the engine as a single `book_req` pulse with stable operands. It samples the engine result after a fixed settle window and returns a tagged response to the host over a valid/ready channel. It sits between the host/command decoder and the reservation engine; one request is in flight at a time.

---
 rtl/booking_req_sequencer_if.sv | 50 +++++
 rtl/booking_req_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_booking_req_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booking_req_sequencer_if.sv
// Host request, engine operand/result and host response channels of booking_req_sequencer.
// slave = sequencer view, master = host/engine view.
interface booking_req_sequencer_if;
    // host request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_train_id;
    logic [2:0]  req_src;
    logic [2:0]  req_dest;
    logic [3:0]  req_num;

    // engine operands and result
    logic        book_req;
    logic        train_id;
    logic [2:0]  src;
    logic [2:0]  dest;
    logic [3:0]  num_tickets;
    logic        eng_success;
    logic [3:0]  eng_count;
    logic [9:0]  eng_fare;
    logic [15:0] eng_total;

    // host response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_tag;
    logic        rsp_success;
    logic        rsp_local_reject;
    logic [3:0]  rsp_count;
    logic [9:0]  rsp_fare;
    logic [15:0] rsp_total;

    modport slave (
        input  req_valid, req_train_id, req_src, req_dest, req_num,
        output req_ready,
        output book_req, train_id, src, dest, num_tickets,
        input  eng_success, eng_count, eng_fare, eng_total,
        output rsp_valid, rsp_tag, rsp_success, rsp_local_reject, rsp_count, rsp_fare, rsp_total,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_train_id, req_src, req_dest, req_num,
        input  req_ready,
        input  book_req, train_id, src, dest, num_tickets,
        output eng_success, eng_count, eng_fare, eng_total,
        input  rsp_valid, rsp_tag, rsp_success, rsp_local_reject, rsp_count, rsp_fare, rsp_total,
        output rsp_ready
    );
endinterface

// File: rtl/booking_req_sequencer.sv
// Queues host booking requests, pre-validates them, issues one at a time to the reservation
// engine and returns a tagged response. Optional counters: define BOOKSEQ_STATS_EN.
module booking_req_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RESULT_WAIT = 5
) (
    input  logic clk,
    input  logic rst_n,
    booking_req_sequencer_if.slave bus
`ifdef BOOKSEQ_STATS_EN
    ,
    output logic [7:0] stat_issued,
    output logic [7:0] stat_ok,
    output logic [7:0] stat_rej
`endif
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [3:0]  WAIT_LOAD = 4'(RESULT_WAIT - 1);

    typedef struct packed {
        logic       train_id;
        logic [2:0] src;
        logic [2:0] dest;
        logic [3:0] num;
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] tag;
    } req_entry_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic        success;
        logic        local_reject;
        logic [3:0]  count;
        logic [9:0]  fare;
        logic [15:0] total;
    } rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    req_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic [3:0]     tag_q;
    logic           ready_q;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [3:0]     cur_tag_q, cur_tag_d;
    logic [3:0]     wait_q, wait_d;
    logic           book_req_q, book_req_d;
    logic           rsp_valid_q, rsp_valid_d;
    rsp_t           rsp_q, rsp_d;

    logic           push_c;
    logic           pop_c;
    logic           reject_c;
    logic           capture_c;

    assign push_c    = bus.req_valid & ready_q;
    assign count_d   = count_q + CW'(push_c) - CW'(pop_c);
    assign capture_c = (state_q == ST_WAIT) && (wait_q == 4'd0);

    // FIFO storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= '{op: '{train_id: bus.req_train_id, src: bus.req_src,
                                     dest: bus.req_dest, num: bus.req_num},
                               tag: tag_q};
        end
    end

    // Pointers, occupancy, tag counter; ready is computed from the next occupancy so a pop
    // never frees a slot for a push at the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                tag_q    <= tag_q + 4'd1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
        end
    end

    // Route and ticket-count validation on the popped operands
    always_comb begin
        reject_c = 1'b0;
        if (op_q.src >= op_q.dest) begin
            reject_c = 1'b1;
        end
        if (!op_q.train_id && (op_q.dest > 3'd4)) begin
            reject_c = 1'b1;
        end
        if (op_q.train_id && (op_q.dest > 3'd3)) begin
            reject_c = 1'b1;
        end
        if ((op_q.num == 4'd0) || (op_q.num > 4'd10)) begin
            reject_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            cur_tag_q   <= '0;
            wait_q      <= '0;
            book_req_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cur_tag_q   <= cur_tag_d;
            wait_q      <= wait_d;
            book_req_q  <= book_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cur_tag_d   = cur_tag_q;
        wait_d      = wait_q;
        book_req_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        pop_c       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_c     = 1'b1;
                    op_d      = mem[rd_ptr_q].op;
                    cur_tag_d = mem[rd_ptr_q].tag;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (reject_c) begin
                    rsp_d              = '0;
                    rsp_d.tag          = cur_tag_q;
                    rsp_d.local_reject = 1'b1;
                    rsp_valid_d        = 1'b1;
                    state_d            = ST_RESP;
                end else begin
                    book_req_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture_c) begin
                    rsp_d.tag          = cur_tag_q;
                    rsp_d.success      = bus.eng_success;
                    rsp_d.local_reject = 1'b0;
                    rsp_d.count        = bus.eng_count;
                    rsp_d.fare         = bus.eng_fare;
                    rsp_d.total        = bus.eng_total;
                    rsp_valid_d        = 1'b1;
                    state_d            = ST_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready        = ready_q;
    assign bus.book_req         = book_req_q;
    assign bus.train_id         = op_q.train_id;
    assign bus.src              = op_q.src;
    assign bus.dest             = op_q.dest;
    assign bus.num_tickets      = op_q.num;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_tag          = rsp_q.tag;
    assign bus.rsp_success      = rsp_q.success;
    assign bus.rsp_local_reject = rsp_q.local_reject;
    assign bus.rsp_count        = rsp_q.count;
    assign bus.rsp_fare         = rsp_q.fare;
    assign bus.rsp_total        = rsp_q.total;

`ifdef BOOKSEQ_STATS_EN
    logic issue_evt_c;
    logic ok_evt_c;
    logic rej_evt_c;

    assign issue_evt_c = (state_q == ST_CHECK) && !reject_c;
    assign ok_evt_c    = capture_c && bus.eng_success;
    assign rej_evt_c   = ((state_q == ST_CHECK) && reject_c) || (capture_c && !bus.eng_success);

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_ok     <= '0;
            stat_rej    <= '0;
        end else begin
            if (issue_evt_c && (stat_issued != 8'hFF)) begin
                stat_issued <= stat_issued + 8'd1;
            end
            if (ok_evt_c && (stat_ok != 8'hFF)) begin
                stat_ok <= stat_ok + 8'd1;
            end
            if (rej_evt_c && (stat_rej != 8'hFF)) begin
                stat_rej <= stat_rej + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_booking_req_sequencer.sv
// Directed, table-driven bench for booking_req_sequencer plus multi-cycle corner sequences.
module tb_booking_req_sequencer;
    localparam int RW    = 5;
    localparam int ISS_K = 2;
    localparam int RSP_K = RW + 3;
    localparam int NV    = 10;

    typedef struct {
        logic        t;
        logic [2:0]  s;
        logic [2:0]  d;
        logic [3:0]  n;
        logic        e_succ;
        logic [3:0]  e_cnt;
        logic [9:0]  e_fare;
        logic [15:0] e_tot;
        logic        x_issue;
        logic        x_succ;
        logic        x_rej;
        logic [3:0]  x_cnt;
        logic [9:0]  x_fare;
        logic [15:0] x_tot;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_tag;

    booking_req_sequencer_if bus();

`ifdef BOOKSEQ_STATS_EN
    logic [7:0] stat_issued;
    logic [7:0] stat_ok;
    logic [7:0] stat_rej;
`endif

    booking_req_sequencer #(.DEPTH(4), .RESULT_WAIT(RW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef BOOKSEQ_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_ok(stat_ok),
        .stat_rej(stat_rej)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs [NV];

    int          o_issues, o_issue_k, o_rsp_k;
    logic        o_train, o_succ, o_rej, o_pulse;
    logic [2:0]  o_src, o_dest;
    logic [3:0]  o_num, o_tag, o_cnt;
    logic [9:0]  o_fare;
    logic [15:0] o_tot;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{bus.book_req, bus.train_id, bus.src, bus.dest, bus.num_tickets, bus.rsp_valid,
                 bus.rsp_tag, bus.rsp_success, bus.rsp_local_reject, bus.rsp_count,
                 bus.rsp_fare, bus.rsp_total};
    endfunction

    task automatic set_eng(input logic s, input logic [3:0] c, input logic [9:0] f, input logic [15:0] t);
        bus.eng_success = s;
        bus.eng_count   = c;
        bus.eng_fare    = f;
        bus.eng_total   = t;
    endtask

    task automatic drive_req(input logic t, input logic [2:0] s, input logic [2:0] d, input logic [3:0] n);
        bus.req_valid    = 1'b1;
        bus.req_train_id = t;
        bus.req_src      = s;
        bus.req_dest     = d;
        bus.req_num      = n;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One request from idle with rsp_ready high; records issue/response timing relative to E0
    task automatic run_req(input logic t, input logic [2:0] s, input logic [2:0] d, input logic [3:0] n);
        drive_req(t, s, d, n);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        o_issues = 0; o_issue_k = -1; o_rsp_k = -1;
        for (int k = 1; k <= 40 && o_rsp_k < 0; k++) begin
            @(posedge clk); #1;
            if (bus.book_req) begin
                o_issues++;
                if (o_issue_k < 0) begin
                    o_issue_k = k;
                    o_train = bus.train_id; o_src = bus.src; o_dest = bus.dest; o_num = bus.num_tickets;
                end
            end
            if (bus.rsp_valid) begin
                o_rsp_k = k;
                o_tag = bus.rsp_tag; o_succ = bus.rsp_success; o_rej = bus.rsp_local_reject;
                o_cnt = bus.rsp_count; o_fare = bus.rsp_fare; o_tot = bus.rsp_total;
            end
        end
        @(posedge clk); #1;
        o_pulse = !bus.rsp_valid;
    endtask

    initial begin
        int accepted, got, unstable, hs, stray;
        logic [3:0]  s_tag, s_cnt;
        logic        s_succ, s_rej;
        logic [9:0]  s_fare;
        logic [15:0] s_tot;

        vecs[0] = '{1'b0, 3'd0, 3'd1, 4'd2,  1'b1, 4'd2, 10'd50,  16'd100, 1'b1, 1'b1, 1'b0, 4'd2, 10'd50,  16'd100};
        vecs[1] = '{1'b1, 3'd2, 3'd2, 4'd1,  1'b1, 4'd5, 10'd60,  16'd300, 1'b0, 1'b0, 1'b1, 4'd0, 10'd0,   16'd0};
        vecs[2] = '{1'b1, 3'd0, 3'd4, 4'd1,  1'b1, 4'd5, 10'd60,  16'd300, 1'b0, 1'b0, 1'b1, 4'd0, 10'd0,   16'd0};
        vecs[3] = '{1'b0, 3'd0, 3'd1, 4'd12, 1'b1, 4'd5, 10'd60,  16'd300, 1'b0, 1'b0, 1'b1, 4'd0, 10'd0,   16'd0};
        vecs[4] = '{1'b0, 3'd0, 3'd4, 4'd10, 1'b0, 4'd3, 10'd7,   16'd21,  1'b1, 1'b0, 1'b0, 4'd3, 10'd7,   16'd21};
        vecs[5] = '{1'b1, 3'd1, 3'd3, 4'd1,  1'b1, 4'd1, 10'd300, 16'd300, 1'b1, 1'b1, 1'b0, 4'd1, 10'd300, 16'd300};
        vecs[6] = '{1'b0, 3'd3, 3'd5, 4'd1,  1'b1, 4'd2, 10'd2,   16'd2,   1'b0, 1'b0, 1'b1, 4'd0, 10'd0,   16'd0};
        vecs[7] = '{1'b0, 3'd2, 3'd1, 4'd1,  1'b1, 4'd2, 10'd2,   16'd2,   1'b0, 1'b0, 1'b1, 4'd0, 10'd0,   16'd0};
        vecs[8] = '{1'b1, 3'd0, 3'd3, 4'd0,  1'b1, 4'd2, 10'd2,   16'd2,   1'b0, 1'b0, 1'b1, 4'd0, 10'd0,   16'd0};
        vecs[9] = '{1'b0, 3'd0, 3'd1, 4'd11, 1'b1, 4'd2, 10'd2,   16'd2,   1'b0, 1'b0, 1'b1, 4'd0, 10'd0,   16'd0};

        total = 0; bad = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_train_id = 1'b0;
        bus.req_src = 3'd0; bus.req_dest = 3'd0; bus.req_num = 4'd0;
        bus.rsp_ready = 1'b1;
        set_eng(1'b0, 4'd0, 10'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", int'(outs_nonzero()), 0);
        chk("reset_req_ready", int'(bus.req_ready), 1);
        rst_n = 1'b1;

        // table-driven single requests
        exp_tag = 0;
        for (int i = 0; i < NV; i++) begin
            set_eng(vecs[i].e_succ, vecs[i].e_cnt, vecs[i].e_fare, vecs[i].e_tot);
            run_req(vecs[i].t, vecs[i].s, vecs[i].d, vecs[i].n);
            chk("issue_count", o_issues, int'(vecs[i].x_issue));
            if (vecs[i].x_issue) begin
                chk("issue_cycle", o_issue_k, ISS_K);
                chk("op_train", int'(o_train), int'(vecs[i].t));
                chk("op_src", int'(o_src), int'(vecs[i].s));
                chk("op_dest", int'(o_dest), int'(vecs[i].d));
                chk("op_num", int'(o_num), int'(vecs[i].n));
                chk("rsp_cycle", o_rsp_k, RSP_K);
            end else begin
                chk("rsp_cycle_reject", o_rsp_k, ISS_K);
            end
            chk("rsp_tag", int'(o_tag), exp_tag);
            chk("rsp_success", int'(o_succ), int'(vecs[i].x_succ));
            chk("rsp_local_reject", int'(o_rej), int'(vecs[i].x_rej));
            chk("rsp_count", int'(o_cnt), int'(vecs[i].x_cnt));
            chk("rsp_fare", int'(o_fare), int'(vecs[i].x_fare));
            chk("rsp_total", int'(o_tot), int'(vecs[i].x_tot));
            chk("rsp_pulse", int'(o_pulse), 1);
            exp_tag = (exp_tag + 1) % 16;
        end

        // FIFO full under response backpressure
        do_reset();
        set_eng(1'b1, 4'd1, 10'd10, 16'd10);
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 3'd0, 3'd1, 4'd1);
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.req_ready) accepted++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk("full_accepted", accepted, 5);
        chk("full_req_ready", int'(bus.req_ready), 0);
        bus.rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && got < 5; k++) begin
            if (bus.rsp_valid) begin
                chk("full_order_tag", int'(bus.rsp_tag), got);
                got++;
            end
            @(posedge clk); #1;
        end
        chk("full_rsp_count", got, 5);
        @(posedge clk); #1;

        // hold response for 20 cycles, engine outputs change underneath
        bus.rsp_ready = 1'b0;
        set_eng(1'b1, 4'd3, 10'd123, 16'd369);
        drive_req(1'b1, 3'd0, 3'd2, 4'd3);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 40 && !bus.rsp_valid; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
        s_tag = bus.rsp_tag; s_succ = bus.rsp_success; s_rej = bus.rsp_local_reject;
        s_cnt = bus.rsp_count; s_fare = bus.rsp_fare; s_tot = bus.rsp_total;
        chk("bp_tag", int'(s_tag), 5);
        chk("bp_success", int'(s_succ), 1);
        chk("bp_count", int'(s_cnt), 3);
        chk("bp_fare", int'(s_fare), 123);
        chk("bp_total", int'(s_tot), 369);
        set_eng(1'b0, 4'd9, 10'd999, 16'd9999);
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.book_req || bus.rsp_tag != s_tag || bus.rsp_success != s_succ ||
                bus.rsp_local_reject != s_rej || bus.rsp_count != s_cnt || bus.rsp_fare != s_fare ||
                bus.rsp_total != s_tot) unstable++;
        end
        chk("bp_stable_cycles_bad", unstable, 0);
        bus.rsp_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.rsp_valid && bus.rsp_ready) hs++;
            @(posedge clk); #1;
        end
        chk("bp_handshakes", hs, 1);

        // tag wrap after 16 requests
        do_reset();
        set_eng(1'b1, 4'd1, 10'd5, 16'd5);
        for (int i = 0; i < 17; i++) begin
            run_req(1'b1, 3'd0, 3'd1, 4'd1);
            chk("wrap_tag", int'(o_tag), i % 16);
        end

        // asynchronous reset during WAIT with one request queued behind
        drive_req(1'b0, 3'd1, 3'd2, 4'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rw_book_req_e2", int'(bus.book_req), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_outputs_zero", int'(outs_nonzero()), 0);
        chk("rw_req_ready", int'(bus.req_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.book_req || bus.rsp_valid) stray++;
        end
        chk("rw_no_activity", stray, 0);
`ifdef BOOKSEQ_STATS_EN
        chk("stat_issued_reset", int'(stat_issued), 0);
        chk("stat_ok_reset", int'(stat_ok), 0);
        chk("stat_rej_reset", int'(stat_rej), 0);
        set_eng(1'b1, 4'd2, 10'd50, 16'd100);
        run_req(1'b0, 3'd0, 3'd1, 4'd2);
        chk("stat_issued_one", int'(stat_issued), 1);
        chk("stat_ok_one", int'(stat_ok), 1);
        chk("stat_rej_none", int'(stat_rej), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
